// File: rtl/p_dec.sv
// p_dec: registered 2-to-4 priority-code decoder with an input FIFO.
//   Codes arrive on a valid/ready stream, are buffered in a DEPTH-entry FIFO
//   and replayed one at a time as a one-hot strobe held for HOLD cycles.
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid, in_code input code stream (2-bit priority code)
//   in_ready          FIFO has room (derived from registered level only)
//   out_valid         out_onehot carries a decoded strobe
//   out_onehot        decoded one-hot, zero when out_valid is low
//   level             current FIFO occupancy
//   busy              strobe in progress or codes still buffered
module p_dec #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [1:0]                 in_code,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [3:0]                 out_onehot,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [CW-1:0] r_cnt;
  state_t        r_state;
  logic          r_out_valid;
  logic [3:0]    r_out_onehot;

  logic          w_push;
  logic          w_pop;
  logic          w_nonempty;

  // Encoder mapping: bit index is the code with its two bits swapped.
  function automatic logic [3:0] f_decode(input logic [1:0] code);
    f_decode = 4'b0001 << {code[0], code[1]};
  endfunction

  assign w_nonempty = (r_level != '0);
  assign in_ready   = (r_level < LW'(DEPTH));
  assign w_push     = in_valid & in_ready;
  // The FSM pops whenever it is free: idle, or the current strobe is on its last cycle.
  assign w_pop      = w_nonempty & ((r_state == S_IDLE) | (r_cnt == '0));

  // FIFO storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= in_code;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Replay FSM with registered strobe outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_onehot <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_out_valid  <= 1'b0;
          r_out_onehot <= '0;
          if (w_nonempty) begin
            r_out_valid  <= 1'b1;
            r_out_onehot <= f_decode(r_mem[r_rptr]);
            r_cnt        <= CW'(HOLD - 1);
            r_state      <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (w_nonempty) begin
            // Back-to-back reload, no gap cycle.
            r_out_onehot <= f_decode(r_mem[r_rptr]);
            r_cnt        <= CW'(HOLD - 1);
          end else begin
            r_out_valid  <= 1'b0;
            r_out_onehot <= '0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_out_valid  <= 1'b0;
          r_out_onehot <= '0;
        end
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_onehot = r_out_onehot;
  assign level      = r_level;
  assign busy       = (r_state == S_DRIVE) | w_nonempty;

endmodule

// File: tb/tb_p_dec.sv
// tb_p_dec: self-checking bench for p_dec (DEPTH=4, HOLD=3).
//   Table-driven mapping sweep, hand sequences for reset/full/wrap corners,
//   and random traffic checked against a queue-based transaction model.
module tb_p_dec;

  localparam int DEPTH = 4;
  localparam int HOLD  = 3;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_code;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_onehot;
  logic [2:0] level;
  logic       busy;

  int total;
  int bad;

  p_dec #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_onehot(out_onehot),
    .level     (level),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of accepted codes plus the strobe being shown.
  logic [1:0] m_q[$];
  bit         m_active;
  int         m_shown;
  logic [1:0] m_cur;

  function automatic logic [3:0] ref_map(input logic [1:0] c);
    case (c)
      2'b11:   return 4'b1000;
      2'b01:   return 4'b0100;
      2'b10:   return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active = 0;
    m_shown  = 0;
    m_cur    = 2'b00;
  endtask

  task automatic model_edge(input bit v, input logic [1:0] c);
    int pre_size;
    pre_size = m_q.size();
    if (m_active && m_shown < HOLD) begin
      m_shown++;
    end else if (pre_size > 0) begin
      m_cur    = m_q.pop_front();
      m_active = 1;
      m_shown  = 1;
    end else begin
      m_active = 0;
    end
    if (v && pre_size < DEPTH) m_q.push_back(c);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("out_valid",  int'(out_valid),  int'(m_active));
    check("out_onehot", int'(out_onehot), m_active ? int'(ref_map(m_cur)) : 0);
    check("level",      int'(level),      m_q.size());
    check("in_ready",   int'(in_ready),   int'(m_q.size() < DEPTH));
    check("busy",       int'(busy),       int'(m_active || m_q.size() > 0));
    check("onehot_cnt", int'($countones(out_onehot) <= 1), 1);
  endtask

  // One clock: drive inputs, clock, advance the model, compare #1 after the edge.
  task automatic step(input bit v, input logic [1:0] c);
    in_valid = v;
    in_code  = c;
    @(posedge clk);
    model_edge(v, c);
    #1;
    check_model();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (busy && n < 60) begin
      step(1'b0, 2'b00);
      n++;
    end
    if (n >= 60) check({name, "_timeout"}, 1, 0);
  endtask

  // Async reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset(input string name);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check({name, "_valid"},  int'(out_valid),  0);
    check({name, "_onehot"}, int'(out_onehot), 0);
    check({name, "_level"},  int'(level),      0);
    check({name, "_ready"},  int'(in_ready),   1);
    check({name, "_busy"},   int'(busy),       0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit         v;
    logic [1:0] c;
    bit         exp_valid;
    logic [3:0] exp_onehot;
    int         exp_level;
  } vec_t;

  vec_t sweep[14];

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_code  = 2'b00;
    model_reset();

    sweep[0]  = '{1, 2'b00, 0, 4'b0000, 1};
    sweep[1]  = '{1, 2'b10, 1, 4'b0001, 1};
    sweep[2]  = '{1, 2'b01, 1, 4'b0001, 2};
    sweep[3]  = '{1, 2'b11, 1, 4'b0001, 3};
    sweep[4]  = '{0, 2'b00, 1, 4'b0010, 2};
    sweep[5]  = '{0, 2'b00, 1, 4'b0010, 2};
    sweep[6]  = '{0, 2'b00, 1, 4'b0010, 2};
    sweep[7]  = '{0, 2'b00, 1, 4'b0100, 1};
    sweep[8]  = '{0, 2'b00, 1, 4'b0100, 1};
    sweep[9]  = '{0, 2'b00, 1, 4'b0100, 1};
    sweep[10] = '{0, 2'b00, 1, 4'b1000, 0};
    sweep[11] = '{0, 2'b00, 1, 4'b1000, 0};
    sweep[12] = '{0, 2'b00, 1, 4'b1000, 0};
    sweep[13] = '{0, 2'b00, 0, 4'b0000, 0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",  int'(out_valid),  0);
    check("rst_onehot", int'(out_onehot), 0);
    check("rst_level",  int'(level),      0);
    check("rst_ready",  int'(in_ready),   1);
    check("rst_busy",   int'(busy),       0);
    rst = 1'b0;

    // Single push of 2'b01: strobe 0100 for edges N+1..N+3, then idle.
    step(1'b1, 2'b01);
    check("single_pre", int'(out_valid), 0);
    for (int i = 0; i < HOLD; i++) begin
      step(1'b0, 2'b00);
      check("single_onehot", int'(out_onehot), 4);
    end
    step(1'b0, 2'b00);
    check("single_end", int'(out_valid), 0);
    check("single_busy", int'(busy), 0);

    // Mapping sweep from the table.
    for (int i = 0; i < 14; i++) begin
      step(sweep[i].v, sweep[i].c);
      check("sweep_valid",  int'(out_valid),  int'(sweep[i].exp_valid));
      check("sweep_onehot", int'(out_onehot), int'(sweep[i].exp_onehot));
      check("sweep_level",  int'(level),      sweep[i].exp_level);
    end

    // Full: in_valid held high with 2'b11 for 8 cycles while draining.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'b11);
      check("full_level_max", int'(level <= 3'(DEPTH)), 1);
    end
    drain("full_drain");

    // Push+pop on the same edge at level 1, then enough pushes to wrap pointers.
    step(1'b1, 2'b10);
    step(1'b1, 2'b01);
    check("pushpop_level", int'(level), 1);
    for (int i = 0; i < 6; i++) step(1'b1, 2'(i));
    drain("wrap_drain");

    // Reset mid-DRIVE with three codes buffered.
    step(1'b1, 2'b00);
    step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    step(1'b1, 2'b11);
    check("pre_rst_level", int'(level), 3);
    async_reset("drive_rst");
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 2'b00);
      check("no_replay", int'(out_valid), 0);
    end

    // Random traffic with bursty valid density.
    for (int i = 0; i < 600; i++) begin
      int dens;
      dens = (i / 100) % 2 == 0 ? 80 : 25;
      step($urandom_range(0, 99) < dens, 2'($urandom_range(0, 3)));
    end
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
